// File: rtl/seq_gen_sched.sv
// Round-robin scheduler that shares one Fibonacci-type sequence generator
// among NUM_REQ requesters and streams each granted burst on a valid/ready port.
module seq_gen_sched #(
  parameter int NUM_REQ = 2,
  parameter int DATA_W  = 32,
  parameter int LEN_W   = 8,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req_valid_i,
  input  logic [NUM_REQ*LEN_W-1:0] req_len_i,
  output logic [NUM_REQ-1:0]       req_ready_o,
  output logic                     gen_restart_o,
  output logic                     gen_step_o,
  input  logic [DATA_W-1:0]        gen_seq_i,
  output logic                     out_valid_o,
  input  logic                     out_ready_i,
  output logic [DATA_W-1:0]        out_data_o,
  output logic [ID_W-1:0]          out_id_o,
  output logic                     out_last_o,
  output logic                     done_o,
  output logic [ID_W-1:0]          done_id_o,
  output logic                     busy_o
);

  typedef enum logic [1:0] {IDLE, RESTART, STREAM, DONE} state_e;

  state_e          state_q, state_d;
  logic [ID_W-1:0] ptr_q, ptr_d;
  logic [ID_W-1:0] id_q, id_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;

  logic            grant_found;
  logic [ID_W-1:0] grant_idx;
  logic            last_beat;

  // Search starts one past the last winner so every requester gets a turn.
  always_comb begin
    int idx;
    grant_found = 1'b0;
    grant_idx   = '0;
    idx         = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(ptr_q) + k) % NUM_REQ;
      if (!grant_found && req_valid_i[idx]) begin
        grant_found = 1'b1;
        grant_idx   = ID_W'(idx);
      end
    end
  end

  assign last_beat = (cnt_q == len_q - LEN_W'(1));

  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    id_d          = id_q;
    len_d         = len_q;
    cnt_d         = cnt_q;
    req_ready_o   = '0;
    gen_restart_o = 1'b0;
    gen_step_o    = 1'b0;
    out_valid_o   = 1'b0;
    out_data_o    = '0;
    out_id_o      = '0;
    out_last_o    = 1'b0;
    done_o        = 1'b0;
    done_id_o     = '0;

    case (state_q)
      IDLE: begin
        // The accept strobe is combinational, so it is masked while reset is held.
        if (grant_found && reset) begin
          req_ready_o[grant_idx] = 1'b1;
          id_d    = grant_idx;
          len_d   = req_len_i[int'(grant_idx)*LEN_W +: LEN_W];
          ptr_d   = grant_idx;
          state_d = RESTART;
        end
      end
      RESTART: begin
        gen_restart_o = 1'b1;
        cnt_d         = '0;
        state_d       = (len_q == '0) ? DONE : STREAM;
      end
      STREAM: begin
        out_valid_o = 1'b1;
        out_data_o  = gen_seq_i;
        out_id_o    = id_q;
        out_last_o  = last_beat;
        if (out_ready_i) begin
          gen_step_o = 1'b1;
          cnt_d      = cnt_q + LEN_W'(1);
          if (last_beat) state_d = DONE;
        end
      end
      DONE: begin
        done_o    = 1'b1;
        done_id_o = id_q;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      ptr_q   <= ID_W'(NUM_REQ - 1);
      id_q    <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      id_q    <= id_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy_o = (state_q != IDLE);

endmodule

// File: tb/tb_seq_gen_sched.sv
// Scoreboard bench for seq_gen_sched with a behavioural Fibonacci generator
// answering the restart/step strobes.
module tb_seq_gen_sched;

  localparam int NUM_REQ = 2;
  localparam int DATA_W  = 32;
  localparam int LEN_W   = 8;
  localparam int ID_W    = 1;

  typedef struct {
    logic [ID_W-1:0]   id;
    logic [DATA_W-1:0] data;
    logic              last;
  } beat_t;

  logic                     clk = 1'b0;
  logic                     rstN = 1'b0;
  logic [NUM_REQ-1:0]       reqValid = '0;
  logic [NUM_REQ*LEN_W-1:0] reqLen = '0;
  logic [NUM_REQ-1:0]       req_ready_o;
  logic                     gen_restart_o, gen_step_o;
  logic [DATA_W-1:0]        genSeq;
  logic                     out_valid_o;
  logic                     outReady = 1'b1;
  logic [DATA_W-1:0]        out_data_o;
  logic [ID_W-1:0]          out_id_o;
  logic                     out_last_o;
  logic                     done_o;
  logic [ID_W-1:0]          done_id_o;
  logic                     busy_o;

  logic [DATA_W-1:0] fibA, fibB;
  beat_t             expQ[$];
  logic [ID_W-1:0]   doneQ[$];
  bit                readyPat[$];
  int vecCount = 0;
  int errCount = 0;
  int cyc = 0;
  int beatsSeen = 0;
  int restartCnt = 0;
  int lastCyc = 0;
  bit pendingLast = 0;

  seq_gen_sched #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .LEN_W(LEN_W), .ID_W(ID_W)) dut (
    .clk(clk), .reset(rstN),
    .req_valid_i(reqValid), .req_len_i(reqLen), .req_ready_o(req_ready_o),
    .gen_restart_o(gen_restart_o), .gen_step_o(gen_step_o), .gen_seq_i(genSeq),
    .out_valid_o(out_valid_o), .out_ready_i(outReady), .out_data_o(out_data_o),
    .out_id_o(out_id_o), .out_last_o(out_last_o),
    .done_o(done_o), .done_id_o(done_id_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  // Generator: presents its new term the cycle after a restart or step.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      fibA <= '0;
      fibB <= 32'd1;
    end else if (gen_restart_o) begin
      fibA <= '0;
      fibB <= 32'd1;
    end else if (gen_step_o) begin
      fibA <= fibB;
      fibB <= fibA + fibB;
    end
  end
  assign genSeq = fibA;

  // Consumer ready follows a queued pattern, then stays high.
  always @(posedge clk) begin
    #1;
    if (readyPat.size() > 0) outReady = readyPat.pop_front();
    else outReady = 1'b1;
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    vecCount++;
    if (observed !== expected) begin
      errCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, observed, expected, cyc);
    end
  endtask

  function automatic logic [DATA_W-1:0] fibAt(input int n);
    logic [DATA_W-1:0] a, b, t;
    a = '0;
    b = 32'd1;
    for (int i = 0; i < n; i++) begin
      t = a + b;
      a = b;
      b = t;
    end
    return a;
  endfunction

  // Monitor: pops the scoreboard on every handshake and on every done pulse.
  always @(negedge clk) begin
    beat_t e;
    cyc++;
    if (rstN) begin
      if (busy_o) begin
        checkOutput("exclusive", 64'(gen_restart_o & gen_step_o), 64'd0);
        checkOutput("stepOnHandshake", 64'(gen_step_o), 64'(out_valid_o & outReady));
      end
      if (gen_restart_o) restartCnt++;
      if (out_valid_o && outReady) begin
        beatsSeen++;
        if (expQ.size() == 0) begin
          checkOutput("extraBeat", 64'd1, 64'd0);
        end else begin
          e = expQ.pop_front();
          checkOutput("data", 64'(out_data_o), 64'(e.data));
          checkOutput("id", 64'(out_id_o), 64'(e.id));
          checkOutput("last", 64'(out_last_o), 64'(e.last));
        end
        if (out_last_o) begin
          pendingLast = 1'b1;
          lastCyc     = cyc;
        end
      end
      if (done_o) begin
        if (doneQ.size() == 0) begin
          checkOutput("extraDone", 64'd1, 64'd0);
        end else begin
          checkOutput("doneId", 64'(done_id_o), 64'(doneQ.pop_front()));
          checkOutput("beatsLeft", 64'(expQ.size()), 64'd0);
        end
        if (pendingLast) checkOutput("doneLatency", 64'(cyc - lastCyc), 64'd1);
        pendingLast = 1'b0;
      end
    end
  end

  task automatic checkResetOutputs(input string tag);
    checkOutput(tag, {req_ready_o, gen_restart_o, gen_step_o, out_valid_o, out_data_o,
                      out_id_o, out_last_o, done_o, done_id_o, busy_o}, 64'd0);
  endtask

  task automatic applyReset();
    @(posedge clk);
    #1 rstN = 1'b0;
    reqValid = '0;
    expQ.delete();
    doneQ.delete();
    readyPat.delete();
    pendingLast = 1'b0;
    #2 checkResetOutputs("resetOutputs");
    repeat (2) @(posedge clk);
    #1 rstN = 1'b1;
  endtask

  // Waits for the next accept strobe, checks who won and loads the scoreboard.
  task automatic grantOne(input int expId);
    bit got;
    int len;
    got = 1'b0;
    for (int c = 0; c < 1000; c++) begin
      @(negedge clk);
      if (req_ready_o != '0) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) begin
      checkOutput("grantTimeout", 64'd0, 64'd1);
    end else begin
      checkOutput("grant", 64'(req_ready_o), 64'd1 << expId);
      len = int'(reqLen[expId*LEN_W +: LEN_W]);
      for (int n = 0; n < len; n++)
        expQ.push_back('{id: ID_W'(expId), data: fibAt(n), last: (n == len - 1)});
      doneQ.push_back(ID_W'(expId));
      @(posedge clk);
      #1 reqValid[expId] = 1'b0;
      reqLen[expId*LEN_W +: LEN_W] = 8'hA5;
    end
  endtask

  task automatic waitIdle();
    bit ok;
    ok = 1'b0;
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk);
      if (!busy_o && expQ.size() == 0 && doneQ.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) checkOutput("burstTimeout", 64'd0, 64'd1);
  endtask

  task automatic applyStimulus(input logic [NUM_REQ-1:0] mask, input int len0, input int len1,
                               input int firstId);
    @(posedge clk);
    #1;
    reqLen[0*LEN_W +: LEN_W] = LEN_W'(len0);
    reqLen[1*LEN_W +: LEN_W] = LEN_W'(len1);
    reqValid = mask;
    grantOne(firstId);
    if (mask == 2'b11) grantOne(1 - firstId);
    waitIdle();
  endtask

  initial begin
    $display("[TB] start");
    #2 checkResetOutputs("resetOutputs");
    repeat (2) @(posedge clk);
    #1 rstN = 1'b1;

    applyStimulus(2'b01, 6, 0, 0);

    applyReset();
    applyStimulus(2'b11, 3, 3, 0);

    readyPat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    applyStimulus(2'b01, 4, 0, 0);

    applyStimulus(2'b11, 3, 3, 1);

    restartCnt = 0;
    applyStimulus(2'b10, 0, 0, 1);
    checkOutput("zeroLenRestarts", 64'(restartCnt), 64'd1);

    // Abort an 8-beat burst while its third beat is on the port.
    @(posedge clk);
    #1;
    reqLen[0 +: LEN_W] = 8'd8;
    reqValid = 2'b01;
    beatsSeen = 0;
    grantOne(0);
    for (int c = 0; c < 100 && beatsSeen < 2; c++) @(negedge clk);
    @(posedge clk);
    #1;
    checkOutput("thirdBeatValid", 64'(out_valid_o), 64'd1);
    rstN = 1'b0;
    expQ.delete();
    doneQ.delete();
    pendingLast = 1'b0;
    #1 checkResetOutputs("midBurstReset");
    repeat (2) @(posedge clk);
    #1 rstN = 1'b1;
    repeat (3) @(negedge clk);
    applyStimulus(2'b11, 2, 2, 0);

    beatsSeen = 0;
    applyStimulus(2'b01, 255, 0, 0);
    checkOutput("beats255", 64'(beatsSeen), 64'd255);

    repeat (5) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vecCount, errCount);
    $finish;
  end

endmodule
